// File: rtl/bus_responder_if.sv
// CPU-to-memory bus bundle: request side driven by the core, completion side by the responder.
interface bus_responder_if;
  logic        req;
  logic [15:0] addr;
  logic        memwrite;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;

  modport master (output req, addr, memwrite, wdata, input rdata, ready);
  modport slave  (input req, addr, memwrite, wdata, output rdata, ready);
endinterface

// File: rtl/bus_responder.sv
// Memory-bus responder: RAM/ROM target with programmable wait states, a one-cycle
// ready strobe, write protection on ROM and a store-triggered test mailbox.
module bus_responder #(
  parameter int unsigned RAM_WORDS   = 256,
  parameter logic [15:0] ROM_BASE    = 16'hF000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] MBOX_ADDR   = 16'h00F0
) (
  input  logic           ph1,
  input  logic           reset_b,
  bus_responder_if.slave bus,
  output logic           done,
  output logic [7:0]     result,
  output logic           rom_wr_err
);
  localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned ROM_BYTES = 32'd65536 - 32'(ROM_BASE);
  localparam int unsigned ROM_AW    = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);
  localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [7:0]  result_q, result_d;
  logic        rom_wr_err_q, rom_wr_err_d;

  // Contents survive reset; the ROM image is loaded hierarchically by the bench.
  logic [7:0] ram_mem [RAM_WORDS];
  logic [7:0] rom_mem [ROM_BYTES];

  logic [ROM_AW-1:0] rom_idx;
  logic [7:0]        read_byte;
  logic              commit_wr;
  logic              ram_hit;
  logic              rom_hit;

  // Decode of the latched access that retires at the end of RESP.
  assign commit_wr = (state_q == RESP) && we_q;
  assign ram_hit   = {1'b0, addr_q} < RAM_LIMIT;
  assign rom_hit   = addr_q >= ROM_BASE;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    done_d       = done_q;
    result_d     = result_q;
    rom_wr_err_d = rom_wr_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          we_d    = bus.memwrite;
          wdata_d = bus.wdata;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES != 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (commit_wr) begin
      if (rom_hit) rom_wr_err_d = 1'b1;
      if (addr_q == MBOX_ADDR) begin
        done_d   = 1'b1;
        result_d = wdata_q;
      end
    end
  end

  // Read data is captured on entry to RESP so it is valid for the whole ready cycle.
  always_comb begin
    rom_idx = ROM_AW'(addr_d - ROM_BASE);
    if ({1'b0, addr_d} < RAM_LIMIT) read_byte = ram_mem[addr_d[RAM_AW-1:0]];
    else if (addr_d >= ROM_BASE)    read_byte = rom_mem[rom_idx];
    else                            read_byte = 8'hFF;
    ready_d = (state_d == RESP);
    rdata_d = (ready_d && !we_d) ? read_byte : rdata_q;
  end

  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 16'h0000;
      we_q         <= 1'b0;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= 8'h00;
      rom_wr_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      result_q     <= result_d;
      rom_wr_err_q <= rom_wr_err_d;
    end
  end

  // A reset during WAIT never reaches RESP, so the pending store is dropped.
  always_ff @(posedge ph1) begin
    if (commit_wr && ram_hit) ram_mem[addr_q[RAM_AW-1:0]] <= wdata_q;
  end

  assign bus.rdata  = rdata_q;
  assign bus.ready  = ready_q;
  assign done       = done_q;
  assign result     = result_q;
  assign rom_wr_err = rom_wr_err_q;
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a WAIT_STATES=2 instance for most steps and a
// WAIT_STATES=0 instance for the zero-latency handshake.
module tb_bus_responder;
  logic       ph1 = 1'b0;
  logic       reset_b;
  logic       done2, done0;
  logic       rom_wr_err2, rom_wr_err0;
  logic [7:0] result2, result0;
  logic [7:0] rd;
  int         errors = 0;
  int         checks = 0;
  int         pulses, firstPulse, lastPulse, lateReady;

  bus_responder_if bus2 ();
  bus_responder_if bus0 ();

  bus_responder #(.WAIT_STATES(2)) dut (
    .ph1(ph1), .reset_b(reset_b), .bus(bus2),
    .done(done2), .result(result2), .rom_wr_err(rom_wr_err2)
  );

  bus_responder #(.WAIT_STATES(0)) dut0 (
    .ph1(ph1), .reset_b(reset_b), .bus(bus0),
    .done(done0), .result(result0), .rom_wr_err(rom_wr_err0)
  );

  always #5 ph1 = ~ph1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One access on the WAIT_STATES=2 instance; the inputs are scrambled after
  // accept so the responder must rely on its latched copy.
  task automatic applyStimulus(input logic [15:0] a, input logic w, input logic [7:0] d,
                               input string tag, output logic [7:0] rdOut);
    int lat;
    @(negedge ph1);
    bus2.req      = 1'b1;
    bus2.addr     = a;
    bus2.memwrite = w;
    bus2.wdata    = d;
    @(negedge ph1);
    bus2.req      = 1'b0;
    bus2.addr     = 16'h0000;
    bus2.memwrite = ~w;
    bus2.wdata    = 8'h00;
    lat = 1;
    while (bus2.ready !== 1'b1 && lat < 20) begin
      @(negedge ph1);
      lat++;
    end
    rdOut = bus2.rdata;
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
  endtask

  initial begin
    reset_b = 1'b1;
    bus2.req = 1'b0; bus2.addr = 16'h0; bus2.memwrite = 1'b0; bus2.wdata = 8'h0;
    bus0.req = 1'b0; bus0.addr = 16'h0; bus0.memwrite = 1'b0; bus0.wdata = 8'h0;
    dut.rom_mem[12'hFFC]  = 8'h00;
    dut.rom_mem[12'hFFD]  = 8'hF0;
    dut.rom_mem[12'h010]  = 8'h9C;
    dut0.rom_mem[12'h010] = 8'h3C;
    #1 reset_b = 1'b0;
    #1;
    checkOutput("rst_ready",  32'(bus2.ready),  32'h0);
    checkOutput("rst_rdata",  32'(bus2.rdata),  32'h00);
    checkOutput("rst_done",   32'(done2),       32'h0);
    checkOutput("rst_result", 32'(result2),     32'h00);
    checkOutput("rst_romerr", 32'(rom_wr_err2), 32'h0);
    checkOutput("rst0_ready", 32'(bus0.ready),  32'h0);
    checkOutput("rst0_done",  32'(done0),       32'h0);
    checkOutput("rst0_result",32'(result0),     32'h00);
    checkOutput("rst0_romerr",32'(rom_wr_err0), 32'h0);
    @(negedge ph1);
    @(negedge ph1);
    reset_b = 1'b1;

    // Reset vector fetch from the top of ROM
    applyStimulus(16'hFFFC, 1'b0, 8'h00, "vec_lo", rd);
    checkOutput("vec_lo_rdata", 32'(rd), 32'h00);
    applyStimulus(16'hFFFD, 1'b0, 8'h00, "vec_hi", rd);
    checkOutput("vec_hi_rdata", 32'(rd), 32'hF0);
    @(negedge ph1);
    checkOutput("ready_one_cycle", 32'(bus2.ready), 32'h0);
    checkOutput("rdata_holds",     32'(bus2.rdata), 32'hF0);

    // RAM write then readback; a write leaves rdata alone
    applyStimulus(16'h0040, 1'b1, 8'h33, "ram_wr", rd);
    checkOutput("ram_wr_rdata_kept", 32'(rd), 32'hF0);
    applyStimulus(16'h0040, 1'b0, 8'h00, "ram_rd", rd);
    checkOutput("ram_rd_rdata", 32'(rd), 32'h33);
    checkOutput("ram_cell_64",  32'(dut.ram_mem[64]), 32'h33);
    checkOutput("ram_no_done",  32'(done2), 32'h0);

    // Mailbox stores
    applyStimulus(16'h00F0, 1'b1, 8'hA5, "mbox1", rd);
    checkOutput("mbox1_done_in_resp", 32'(done2), 32'h0);
    @(negedge ph1);
    checkOutput("mbox1_done",   32'(done2),   32'h1);
    checkOutput("mbox1_result", 32'(result2), 32'hA5);
    applyStimulus(16'h00F0, 1'b1, 8'h5A, "mbox2", rd);
    @(negedge ph1);
    checkOutput("mbox2_done",   32'(done2),   32'h1);
    checkOutput("mbox2_result", 32'(result2), 32'h5A);
    applyStimulus(16'h00F0, 1'b0, 8'h00, "mbox_rd", rd);
    checkOutput("mbox_rd_rdata", 32'(rd), 32'h5A);

    // ROM protection and unmapped space
    applyStimulus(16'hF010, 1'b1, 8'h12, "rom_wr", rd);
    @(negedge ph1);
    checkOutput("rom_wr_err", 32'(rom_wr_err2), 32'h1);
    applyStimulus(16'hF010, 1'b0, 8'h00, "rom_rd", rd);
    checkOutput("rom_rd_rdata", 32'(rd), 32'h9C);
    applyStimulus(16'h8000, 1'b1, 8'h44, "unm_wr", rd);
    applyStimulus(16'h8000, 1'b0, 8'h00, "unm_rd", rd);
    checkOutput("unm_rd_rdata", 32'(rd), 32'hFF);

    // req held high: ready every WAIT_STATES+2 cycles, first at accept+3
    @(negedge ph1);
    bus2.req = 1'b1; bus2.addr = 16'hFFFD; bus2.memwrite = 1'b0;
    pulses = 0; firstPulse = 0; lastPulse = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge ph1);
      if (bus2.ready === 1'b1) begin
        if (pulses == 0) firstPulse = i;
        else checkOutput("held_spacing", 32'(i - lastPulse), 32'd4);
        lastPulse = i;
        pulses++;
      end
    end
    checkOutput("held_pulses", 32'(pulses),     32'd3);
    checkOutput("held_first",  32'(firstPulse), 32'd3);

    // The access accepted last is in WAIT now; dropping req must not abort it
    bus2.req = 1'b0;
    @(negedge ph1);
    checkOutput("drop_still_wait", 32'(bus2.ready), 32'h0);
    @(negedge ph1);
    checkOutput("drop_completes",  32'(bus2.ready), 32'h1);
    checkOutput("drop_rdata",      32'(bus2.rdata), 32'hF0);

    // Zero wait states: ready in the cycle right after accept
    @(negedge ph1);
    bus0.req = 1'b1; bus0.addr = 16'hF010; bus0.memwrite = 1'b0;
    @(negedge ph1);
    bus0.req = 1'b0;
    checkOutput("ws0_ready", 32'(bus0.ready), 32'h1);
    checkOutput("ws0_rdata", 32'(bus0.rdata), 32'h3C);
    @(negedge ph1);
    checkOutput("ws0_ready_off", 32'(bus0.ready), 32'h0);

    // Reset during WAIT of a store: dropped, outputs clear at once
    applyStimulus(16'h0010, 1'b1, 8'h11, "pre_wr", rd);
    @(negedge ph1);
    @(negedge ph1);
    bus2.req = 1'b1; bus2.addr = 16'h0010; bus2.memwrite = 1'b1; bus2.wdata = 8'h77;
    @(negedge ph1);
    bus2.req = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    checkOutput("mid_rst_ready",  32'(bus2.ready),  32'h0);
    checkOutput("mid_rst_rdata",  32'(bus2.rdata),  32'h00);
    checkOutput("mid_rst_done",   32'(done2),       32'h0);
    checkOutput("mid_rst_result", 32'(result2),     32'h00);
    checkOutput("mid_rst_romerr", 32'(rom_wr_err2), 32'h0);
    @(negedge ph1);
    @(negedge ph1);
    reset_b = 1'b1;
    lateReady = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ph1);
      if (bus2.ready !== 1'b0) lateReady++;
    end
    checkOutput("mid_rst_no_ready", 32'(lateReady), 32'd0);
    checkOutput("mid_rst_ram16", 32'(dut.ram_mem[16]), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Single-clock memory-bus responder: the target end of the CPU memory interface.
- Serves CPU read/write requests to on-block RAM and ROM with a programmable wait-state count, answering through a `ready` handshake.
- Provides a test mailbox: a CPU store to `MBOX_ADDR` raises `done` and captures the byte, so benches can end a program without peeking into RAM.
- Sits between the core and the bench in the system-level harness; intended as the drop-in replacement for the zero-latency behavioural memory.

Parameters:
- `RAM_WORDS`, 256: RAM bytes, mapped at 0x0000 to `RAM_WORDS`-1.
- `ROM_BASE`, 16'hF000: ROM base address; ROM spans `ROM_BASE` to 0xFFFF, 4096 bytes at the default.
- `WAIT_STATES`, 2: cycles inserted between accept and response, range 0 to 15.
- `MBOX_ADDR`, 16'h00F0: mailbox address, which overlays RAM.

Ports:
- `ph1`  in  1  clock; all state updates on the rising edge.
- `reset_b`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request from the CPU.
- `addr`  in  16  byte address.
- `memwrite`  in  1  1 = write, 0 = read.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle completion strobe.
- `done`  out  1  sticky; set by a mailbox write.
- `result`  out  8  byte from the last mailbox write.
- `rom_wr_err`  out  1  sticky; set by any write into the ROM range.

Behaviour:

Reset
- Asserted asynchronously when `reset_b`=0.
- Forces state IDLE, `ready`=0, `rdata`=8'h00, `done`=0, `result`=8'h00, `rom_wr_err`=0, wait counter 0.
- RAM and ROM contents are preserved. ROM is loaded only by hierarchical `$readmemh` from the bench.
- Reset mid-access drops the pending access: no write is performed and no `ready` is issued.

State machine (IDLE, WAIT, RESP)
- IDLE
  - When `req`=1, latch `addr`, `memwrite` and `wdata`, and load the counter with `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES`>0, otherwise RESP.
  - `req`=0 stays in IDLE.
- WAIT
  - Decrement the counter each cycle; move to RESP on the cycle the counter equals 1.
  - `req` and the address/data inputs are ignored here. A `req` drop does not abort the access, because it was latched at accept.
- RESP
  - `ready`=1 for exactly one cycle.
  - Write: commit at the RESP edge.
  - Read: `rdata` is driven from the latched address during RESP.
  - Return unconditionally to IDLE. `req` seen in RESP is not accepted; it is accepted in the following IDLE cycle.
- Latency from the accept edge to `ready`=1 is `WAIT_STATES`+1 cycles. Minimum spacing between accepts is `WAIT_STATES`+2 cycles.

Address decode (on the latched address)
- `addr` < `RAM_WORDS`: RAM read/write.
- `addr` >= `ROM_BASE`: ROM read. A write is discarded and sets `rom_wr_err`.
- Otherwise unmapped: reads return 8'hFF; writes are discarded with no error.
- `addr` == `MBOX_ADDR` with a write
  - Writes RAM as normal, sets `result`=`wdata` and sets `done`=1.
  - A later mailbox write overwrites `result`; `done` stays 1.
  - A mailbox read returns the RAM byte.

Outputs
- `rdata` holds its last value outside RESP.
- `rdata` is unchanged by writes.

Test Plan:
- Reset and vector read, `WAIT_STATES`=2:
  - Stimulus: ROM[0xFFC]=8'h00 and ROM[0xFFD]=8'hF0, then read 0xFFFC and 0xFFFD.
  - Required: `ready` pulses 3 cycles after each accept; `rdata`=8'h00, then 8'hF0.
  - Required after reset: `done`=0 and `result`=8'h00.
- RAM write and readback:
  - Stimulus: write 8'h33 to 0x0040, then read 0x0040.
  - Required: read `rdata`=8'h33 and RAM[64]=8'h33; `done` stays 0.
- Mailbox:
  - Stimulus: write 8'hA5 to 0x00F0.
  - Required: `done`=1 and `result`=8'hA5 in the cycle after RESP.
  - Stimulus: then write 8'h5A to 0x00F0.
  - Required: `result`=8'h5A, `done` still 1.
- ROM protection and unmapped access:
  - Stimulus: write 8'h12 to 0xF010, then read 0xF010.
  - Required: the original ROM byte is returned and `rom_wr_err`=1.
  - Stimulus: read 0x8000.
  - Required: `rdata`=8'hFF.
- Handshake edges:
  - `WAIT_STATES`=0: `ready` appears 1 cycle after accept.
  - `req` dropped during WAIT: the access still completes with `ready`.
  - `req` held high continuously: accepts occur every `WAIT_STATES`+2 cycles.
- Reset mid-access:
  - Stimulus: assert `reset_b`=0 during WAIT of a write of 8'h77 to 0x0010.
  - Required: no `ready`; RAM[16] unchanged; all outputs return to their reset values immediately, without waiting for a clock edge.
